// File: rtl/otter_pkg.sv
// Shared types and constants for the pipeline's memory-side blocks.
package otter_pkg;

   // Which requester the read data arriving next cycle belongs to.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   // Access size code for a full 32-bit word.
   localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage : otter_pkg

// File: rtl/starve_counter.sv
// Saturating 4-bit counter used to bound how long fetch can be denied.
// clr has priority over inc. sat is high while the count equals STARVE_MAX.
module starve_counter #(
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] cnt_o,
   output logic       sat_o
);

   localparam logic [3:0] MAX_CNT = 4'(STARVE_MAX);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Next count: clear wins, otherwise count up until saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 4'd0;
      end else if (inc && (cnt_q != MAX_CNT)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Count register, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign sat_o = (cnt_q == MAX_CNT);

endmodule : starve_counter

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and the
// load/store stage. Data normally wins a conflict; fetch wins once it has
// been denied STARVE_MAX cycles in a row. Read data returns one cycle after
// the grant and is steered to whichever requester owned that read.
//
// Handshake: a requester raises req with stable address/data and keeps them
// until it sees gnt in the same cycle; gnt is combinational (zero latency)
// and a dropped req is simply forgotten. rvalid pulses for one cycle, the
// cycle after a read grant; stores never produce rvalid.
module mem_port_arbiter
   import otter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        RESET_n,
   // instruction fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   // data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_size,
   input  logic        d_sign,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   // shared memory port
   output logic        mem_rden,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_size,
   output logic        mem_sign,
   input  logic [31:0] mem_rdata,
   // state visibility
   output owner_t      dbg_owner,
   output logic [3:0]  dbg_starve_cnt
);

   owner_t owner_q;
   owner_t owner_d;
   logic   starve_sat;

   starve_counter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk   (clk),
      .rst_n (RESET_n),
      .inc   (if_req & ~if_gnt),
      .clr   (if_gnt | ~if_req),
      .cnt_o (dbg_starve_cnt),
      .sat_o (starve_sat)
   );

   // Grant selection and memory-port mux; nothing is granted in reset.
   always_comb begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      mem_rden  = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_size  = 2'b00;
      mem_sign  = 1'b0;
      owner_d   = OWN_NONE;
      if (RESET_n) begin
         if (if_req && (!d_req || starve_sat)) begin
            if_gnt   = 1'b1;
            mem_rden = 1'b1;
            mem_addr = if_addr;
            mem_size = SIZE_WORD;
            owner_d  = OWN_IF;
         end else if (d_req) begin
            d_gnt     = 1'b1;
            mem_rden  = ~d_we;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_size  = d_size;
            mem_sign  = d_sign;
            owner_d   = d_we ? OWN_NONE : OWN_D;
         end
      end
   end

   // Remember who owns the read in flight so the response can be steered.
   always_ff @(posedge clk or negedge RESET_n) begin
      if (!RESET_n) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   assign if_rvalid = (owner_q == OWN_IF);
   assign d_rvalid  = (owner_q == OWN_D);
   assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
   assign d_rdata   = d_rvalid  ? mem_rdata : 32'd0;
   assign dbg_owner = owner_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_mem_port_arbiter;

  localparam int SMAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RESET_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_sign;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_rden, mem_we, mem_sign;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic [1:0]  dbg_owner;
  logic [3:0]  dbg_starve_cnt;

  mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk            (clk),
    .RESET_n        (RESET_n),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_gnt         (if_gnt),
    .if_rvalid      (if_rvalid),
    .if_rdata       (if_rdata),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_size         (d_size),
    .d_sign         (d_sign),
    .d_gnt          (d_gnt),
    .d_rvalid       (d_rvalid),
    .d_rdata        (d_rdata),
    .mem_rden       (mem_rden),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_size       (mem_size),
    .mem_sign       (mem_sign),
    .mem_rdata      (mem_rdata),
    .dbg_owner      (dbg_owner),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: denied-fetch streak length and a queue holding the
  // owner (1 = fetch, 2 = data) of each read whose data is due next cycle.
  int          m_cnt = 0;
  logic [1:0]  exp_q[$];
  logic [1:0]  pend;
  logic        e_if_gnt = 1'b0;
  logic        e_d_gnt  = 1'b0;
  logic        e_rden, e_we, e_sign;
  logic [31:0] e_addr, e_wdata;
  logic [1:0]  e_size;

  // Compare process: every cycle, mid-period, inputs are stable.
  always @(negedge clk) begin
    if (!RESET_n) begin
      m_cnt = 0;
      exp_q.delete();
    end
    pend = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;

    e_if_gnt = RESET_n && if_req && (!d_req || m_cnt == SMAX);
    e_d_gnt  = RESET_n && d_req && !e_if_gnt;
    e_rden   = e_if_gnt || (e_d_gnt && !d_we);
    e_we     = e_d_gnt && d_we;
    e_addr   = e_if_gnt ? if_addr : (e_d_gnt ? d_addr : 32'd0);
    e_wdata  = e_d_gnt ? d_wdata : 32'd0;
    e_size   = e_if_gnt ? 2'b10 : (e_d_gnt ? d_size : 2'b00);
    e_sign   = e_d_gnt ? d_sign : 1'b0;

    chk("if_gnt", if_gnt, e_if_gnt);
    chk("d_gnt", d_gnt, e_d_gnt);
    chk("mem_rden", mem_rden, e_rden);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_size", mem_size, e_size);
    chk("mem_sign", mem_sign, e_sign);
    chk("if_rvalid", if_rvalid, pend == 2'd1);
    chk("d_rvalid", d_rvalid, pend == 2'd2);
    chk("if_rdata", if_rdata, (pend == 2'd1) ? mem_rdata : 32'd0);
    chk("d_rdata", d_rdata, (pend == 2'd2) ? mem_rdata : 32'd0);
    chk("owner", dbg_owner, pend);
    chk("starve_cnt", dbg_starve_cnt, m_cnt);

    if (RESET_n) begin
      if (e_if_gnt) exp_q.push_back(2'd1);
      else if (e_d_gnt && !d_we) exp_q.push_back(2'd2);
      if (if_req && !e_if_gnt) m_cnt = (m_cnt < SMAX) ? m_cnt + 1 : SMAX;
      else m_cnt = 0;
    end else begin
      m_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    d_size = 2'd0; d_sign = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  int n_if;

  initial begin
    idle();
    RESET_n   = 1'b0;
    mem_rdata = 32'd0;
    if_req    = 1'b1;
    sample();
    chk("rst_if_gnt", if_gnt, 1'b0);
    chk("rst_mem_rden", mem_rden, 1'b0);
    chk("rst_owner", dbg_owner, 2'd0);
    step(); RESET_n = 1'b1; idle();

    // fetch read
    step(); if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'h00A00093;
    sample();
    chk("t1_if_gnt", if_gnt, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h40);
    step(); idle();
    sample();
    chk("t1_if_rvalid", if_rvalid, 1'b1);
    chk("t1_if_rdata", if_rdata, 32'h00A00093);
    chk("t1_d_rvalid", d_rvalid, 1'b0);

    // data load
    step(); d_req = 1'b1; d_addr = 32'h11000000; d_size = 2'd2; mem_rdata = 32'h1234;
    sample();
    chk("t2_d_gnt", d_gnt, 1'b1);
    chk("t2_mem_rden", mem_rden, 1'b1);
    chk("t2_mem_we", mem_we, 1'b0);
    step(); idle();
    sample();
    chk("t2_d_rvalid", d_rvalid, 1'b1);
    chk("t2_d_rdata", d_rdata, 32'h1234);

    // data store
    step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000; d_wdata = 32'hDEADBEEF;
    sample();
    chk("t3_mem_we", mem_we, 1'b1);
    chk("t3_mem_rden", mem_rden, 1'b0);
    chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    step(); idle();
    sample();
    chk("t3_if_rvalid", if_rvalid, 1'b0);
    chk("t3_d_rvalid", d_rvalid, 1'b0);

    // both requesting continuously (data side storing)
    n_if = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if_req = 1'b1; if_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55AA55AA;
      sample();
      chk("t4_if_gnt", if_gnt, (k % 4) == 3);
      chk("t4_d_gnt", d_gnt, (k % 4) != 3);
      if (if_gnt) n_if++;
    end
    chk("t4_fetch_total", n_if, 3);

    // alternating D, IF, D reads
    step(); idle(); d_req = 1'b1; d_addr = 32'h300; mem_rdata = 32'd0;
    sample();
    chk("t5_d_gnt0", d_gnt, 1'b1);
    step(); idle(); if_req = 1'b1; if_addr = 32'h304; mem_rdata = 32'hA0A0A0A0;
    sample();
    chk("t5_d_rvalid0", d_rvalid, 1'b1);
    chk("t5_d_rdata0", d_rdata, 32'hA0A0A0A0);
    chk("t5_if_gnt1", if_gnt, 1'b1);
    step(); idle(); d_req = 1'b1; d_addr = 32'h308; mem_rdata = 32'hB1B1B1B1;
    sample();
    chk("t5_if_rvalid1", if_rvalid, 1'b1);
    chk("t5_if_rdata1", if_rdata, 32'hB1B1B1B1);
    chk("t5_d_rvalid1", d_rvalid, 1'b0);
    step(); idle(); mem_rdata = 32'hC2C2C2C2;
    sample();
    chk("t5_d_rvalid2", d_rvalid, 1'b1);
    chk("t5_d_rdata2", d_rdata, 32'hC2C2C2C2);
    chk("t5_if_rvalid2", if_rvalid, 1'b0);

    // reset pulse while a fetch read is outstanding
    step(); idle(); if_req = 1'b1; if_addr = 32'h80;
    sample();
    chk("t6_if_gnt", if_gnt, 1'b1);
    step(); idle(); RESET_n = 1'b0;
    sample();
    chk("t6_if_rvalid", if_rvalid, 1'b0);
    chk("t6_owner", dbg_owner, 2'd0);
    step(); RESET_n = 1'b1;
    sample();
    chk("t6_owner_rel", dbg_owner, 2'd0);
    chk("t6_cnt_rel", dbg_starve_cnt, 4'd0);
    chk("t6_if_rvalid_rel", if_rvalid, 1'b0);

    // randomized traffic; requesters hold until granted
    for (int c = 0; c < 600; c++) begin
      step();
      if (!RESET_n) RESET_n = 1'b1;
      else if ($urandom_range(0, 63) == 0) RESET_n = 1'b0;
      if (!if_req || e_if_gnt) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req || e_d_gnt) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_size  = 2'($urandom_range(0, 3));
        d_sign  = $urandom_range(0, 1) == 1;
      end
      mem_rdata = $urandom;
    end

    step(); idle();
    step();
    sample();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one synchronous memory port between the pipeline's instruction-fetch stage and its data (load/store) stage. Each cycle it grants at most one request, drives the shared memory address, control and write data, and routes the read data back to the winning requester one cycle later. A starvation counter guarantees forward progress for fetch. It sits between the pipeline stages and the `Memory` block and replaces the separate fetch and data ports with one arbitrated port.

## Interface
Parameters:
- `STARVE_MAX`, default 3: consecutive denied fetch cycles after which fetch wins unconditionally. Legal range 1–15.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `RESET_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  `if_rdata` valid.
- `if_rdata`  out  32  fetched word.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_size`  in  2  access size, passed through.
- `d_sign`  in  1  load sign-extend, passed through.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  `d_rdata` valid (loads only).
- `d_rdata`  out  32  load data.
- `mem_rden`  out  1  memory read enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  memory byte address.
- `mem_wdata`  out  32  memory write data.
- `mem_size`  out  2  memory access size.
- `mem_sign`  out  1  memory sign control.
- `mem_rdata`  in  32  memory read data, valid one cycle after `mem_rden`.

## Operation
- Grant logic is combinational from the requests, `starve_cnt` and `RESET_n`:
  - both requests low: no grant; all `mem_*` controls are 0.
  - one request high: that requester is granted.
  - both high: data wins, unless `starve_cnt == STARVE_MAX`, in which case fetch wins.
- Granted fetch: `mem_rden=1`, `mem_we=0`, `mem_addr=if_addr`, `mem_size=2'b10`, `mem_sign=0`.
- Granted data: `mem_rden=~d_we`, `mem_we=d_we`, and `d_addr`, `d_wdata`, `d_size`, `d_sign` are passed through.
- When nothing is granted, `mem_addr` and `mem_wdata` are 0.
- Owner register `owner` ∈ {`OWN_NONE`, `OWN_IF`, `OWN_D`} updates every cycle:
  - granted read → owner = that requester;
  - granted store → `OWN_NONE`;
  - no grant → `OWN_NONE`.
- Response routing, the cycle after a read grant:
  - `if_rvalid = (owner==OWN_IF)` and `d_rvalid = (owner==OWN_D)`;
  - the rvalid-owning port receives `mem_rdata`;
  - the other port's rdata is 0.
- Starvation counter `starve_cnt` (4-bit):
  - increments when `if_req & ~if_gnt`, saturating at `STARVE_MAX`;
  - clears to 0 on any cycle with `if_gnt=1`, or with `if_req=0`.
- A requester holds `req` and its address/data stable until it sees `gnt`. A dropped `req` is not remembered.
- Stores complete in the grant cycle and produce no rvalid.

## Timing
- Reset (async assert, synchronous release):
  - `owner=OWN_NONE`, `starve_cnt=0`;
  - `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `mem_rden` and `mem_we` are all 0;
  - all data outputs are 0;
  - while `RESET_n=0` no grant is issued.
- Grant latency is 0 cycles (same cycle as `req`). Read data latency is 1 cycle after `gnt`.
- Throughput is one access per cycle. Back-to-back reads from alternating requesters are legal; `owner` pipelines correctly.
- Reset asserted while a read is outstanding: the pending rvalid is dropped and `owner` returns to `OWN_NONE`.
- With both requesting continuously, fetch is granted exactly once every `STARVE_MAX+1` cycles.
- The `STARVE_MAX` override applies even when the data request is a store.

## Structure
- The shared package `otter_pkg` holds:
  - the `owner_t` enum (`OWN_NONE=2'd0`, `OWN_IF=2'd1`, `OWN_D=2'd2`);
  - the constant `SIZE_WORD=2'b10`.
- One sub-module, `starve_counter`: a saturating counter with `inc`/`clr` inputs, a `STARVE_MAX` parameter and a `sat` output.
- Everything else is flat: grant/mux logic and the `owner` register.

## Test plan
- Reset, then `if_req=1`, `if_addr=0x40`, `mem_rdata=0x00A00093` → `if_gnt=1` with `mem_addr=0x40`; next cycle `if_rvalid=1`, `if_rdata=0x00A00093`, `d_rvalid=0`.
- Load only, `d_addr=0x11000000`, `d_size=2`, `mem_rdata=0x1234` → `d_gnt=1`, `mem_rden=1`, `mem_we=0`; next cycle `d_rvalid=1`, `d_rdata=0x1234`.
- Store `d_we=1`, `d_addr=0x8000`, `d_wdata=0xDEADBEEF` → `mem_we=1`, `mem_rden=0`, `mem_wdata=0xDEADBEEF`; next cycle both rvalids are 0.
- Both requests held high for 12 cycles, `STARVE_MAX=3` → `d_gnt` on cycles 0–2, `if_gnt` on cycle 3, and the pattern repeats; fetch is granted 3 times in total.
- Alternating grants D, IF, D on consecutive cycles → rvalid sequence `d`, `if`, `d`, each carrying the `mem_rdata` of the matching cycle.
- `RESET_n` pulsed low one cycle after a fetch grant → no `if_rvalid`; `owner` and `starve_cnt` read 0 after release.
